// File: rtl/memstream_rx_fifo.sv
// rtl/memstream_rx_fifo.sv - receive FIFO turning an afull-throttled stream into a ready/valid stream
// Circular buffer plus a registered output stage; count covers both.
module memstream_rx_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 32,
  parameter int AFULL_SLACK = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  input  logic [WIDTH-1:0]         s_axis_tdata,
  output logic                     s_axis_tready,
  output logic                     s_axis_afull,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [WIDTH-1:0]         m_axis_tdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_SLACK);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AFULL_SLACK < 1) || (AFULL_SLACK > DEPTH - 1)) begin : g_param_check
    initial begin
      $display("memstream_rx_fifo: illegal DEPTH=%0d / AFULL_SLACK=%0d", DEPTH, AFULL_SLACK);
      $finish;
    end
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             accept;
  logic             deliver;
  logic             load;
  logic [CW-1:0]    count_next;

  assign accept  = s_axis_tvalid & s_axis_tready;
  assign deliver = m_axis_tvalid & m_axis_tready;
  // Output register refills from the buffer only, never straight from the s-side.
  assign load    = (wptr != rptr) & (~m_axis_tvalid | m_axis_tready);

  always_comb begin
    count_next = count;
    if (accept & ~deliver)
      count_next = count + 1'b1;
    else if (~accept & deliver)
      count_next = count - 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b1;
      s_axis_afull  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (accept)
        wptr <= wptr + 1'b1;
      if (load)
        rptr <= rptr + 1'b1;
      if (load)
        m_axis_tvalid <= 1'b1;
      else if (deliver)
        m_axis_tvalid <= 1'b0;
      count         <= count_next;
      s_axis_tready <= (count_next != FULL_LVL);
      s_axis_afull  <= (count_next >= AFULL_LVL);
      // A beat offered while full is lost even if a word leaves this cycle.
      if (s_axis_tvalid & ~s_axis_tready)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (accept)
      mem[wptr[AW-1:0]] <= s_axis_tdata;
    if (load)
      m_axis_tdata <= mem[rptr[AW-1:0]];
  end

endmodule
